// File: rtl/dht11_pkg.sv
// Shared encodings for the DHT11 bus controller: FSM states, status codes and
// frame geometry.
package dht11_pkg;

   localparam int unsigned FRAME_BITS = 40;

   typedef logic [3:0] state_t;

   localparam state_t S_IDLE      = 4'd0;
   localparam state_t S_START_LOW = 4'd1;
   localparam state_t S_RELEASE   = 4'd2;
   localparam state_t S_RESP_LOW  = 4'd3;
   localparam state_t S_RESP_HIGH = 4'd4;
   localparam state_t S_BIT_LOW   = 4'd5;
   localparam state_t S_BIT_HIGH  = 4'd6;
   localparam state_t S_CHECK     = 4'd7;
   localparam state_t S_ERR       = 4'd8;
   localparam state_t S_FIN       = 4'd9;

   typedef logic [1:0] status_t;

   localparam status_t ST_OK      = 2'd0;
   localparam status_t ST_NORESP  = 2'd1;
   localparam status_t ST_TIMEOUT = 2'd2;
   localparam status_t ST_CKSUM   = 2'd3;

   function automatic int unsigned max2(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/dht11_bus_controller_dq_sync.sv
// Two-flop synchroniser for the raw DQ pad plus single-cycle rise/fall pulses.
module dht11_dq_sync (
   input  logic clk,
   input  logic rst,
   input  logic dq_in,
   output logic rise,
   output logic fall
);

   logic meta;
   logic sync;
   logic prev;

   // Reset to the idle (pulled-up) level so leaving reset creates no edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= 1'b1;
         sync <= 1'b1;
         prev <= 1'b1;
      end else begin
         meta <= dq_in;
         sync <= meta;
         prev <= sync;
      end
   end

   assign rise = sync & ~prev;
   assign fall = ~sync & prev;

endmodule

// File: rtl/dht11_bus_controller.sv
// One complete DHT11 transaction per accepted start: host start pulse, sensor
// response handshake, 40-bit MSB-first read and checksum verification.
module dht11_bus_controller
   import dht11_pkg::*;
#(
   parameter int unsigned START_LOW_CYC  = 18000,
   parameter int unsigned RELEASE_CYC    = 30,
   parameter int unsigned TIMEOUT_CYC    = 200,
   parameter int unsigned BIT_THRESH_CYC = 50,
   parameter int unsigned HOLDOFF_CYC    = 1000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       dq_in,
   output logic       dq_oe,
   output logic       busy,
   output logic       done,
   output logic [1:0] status,
   output logic [7:0] hum_int,
   output logic [7:0] hum_dec,
   output logic [7:0] temp_int,
   output logic [7:0] temp_dec
);

   localparam int unsigned MAX_CYC = max2(max2(max2(START_LOW_CYC, RELEASE_CYC + TIMEOUT_CYC),
                                               max2(TIMEOUT_CYC, BIT_THRESH_CYC)),
                                          HOLDOFF_CYC);
   localparam int unsigned CW = $clog2(MAX_CYC) + 1;

   localparam logic [CW-1:0] START_LAST = CW'(START_LOW_CYC - 1);
   localparam logic [CW-1:0] REL_LAST   = CW'(RELEASE_CYC + TIMEOUT_CYC - 1);
   localparam logic [CW-1:0] TMO_LAST   = CW'(TIMEOUT_CYC - 1);
   localparam logic [CW-1:0] THRESH     = CW'(BIT_THRESH_CYC);
   localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLDOFF_CYC - 1);
   localparam logic [CW-1:0] CNT_ONE    = CW'(1);
   localparam logic [5:0]    LAST_IDX   = 6'(FRAME_BITS - 1);

   logic                  rise;
   logic                  fall;
   state_t                state;
   state_t                state_nx;
   logic [CW-1:0]         cnt;
   logic [5:0]            idx;
   logic [FRAME_BITS-1:0] sr;
   status_t               code;
   status_t               code_nx;
   logic                  holdoff_ok;
   logic [7:0]            cksum;

   dht11_dq_sync u_sync (
      .clk   (clk),
      .rst   (rst),
      .dq_in (dq_in),
      .rise  (rise),
      .fall  (fall)
   );

   assign cksum = sr[39:32] + sr[31:24] + sr[23:16] + sr[15:8];

   always_comb begin
      state_nx = state;
      code_nx  = code;
      case (state)
         S_IDLE: begin
            if (start && holdoff_ok) state_nx = S_START_LOW;
         end
         S_START_LOW: begin
            if (cnt == START_LAST) state_nx = S_RELEASE;
         end
         S_RELEASE: begin
            if (fall) begin
               state_nx = S_RESP_LOW;
            end else if (cnt == REL_LAST) begin
               state_nx = S_ERR;
               code_nx  = ST_NORESP;
            end
         end
         S_RESP_LOW: begin
            if (rise) begin
               state_nx = S_RESP_HIGH;
            end else if (cnt == TMO_LAST) begin
               state_nx = S_ERR;
               code_nx  = ST_NORESP;
            end
         end
         S_RESP_HIGH: begin
            if (fall) begin
               state_nx = S_BIT_LOW;
            end else if (cnt == TMO_LAST) begin
               state_nx = S_ERR;
               code_nx  = ST_NORESP;
            end
         end
         S_BIT_LOW: begin
            if (rise) begin
               state_nx = S_BIT_HIGH;
            end else if (cnt == TMO_LAST) begin
               state_nx = S_ERR;
               code_nx  = ST_TIMEOUT;
            end
         end
         S_BIT_HIGH: begin
            // The closing edge of bit 39 is the sensor's end-of-frame low pulse.
            if (fall) begin
               state_nx = (idx == LAST_IDX) ? S_CHECK : S_BIT_LOW;
            end else if (cnt == TMO_LAST) begin
               state_nx = S_ERR;
               code_nx  = ST_TIMEOUT;
            end
         end
         S_CHECK: begin
            state_nx = S_FIN;
            code_nx  = (cksum == sr[7:0]) ? ST_OK : ST_CKSUM;
         end
         S_ERR: begin
            state_nx = S_FIN;
         end
         S_FIN: begin
            state_nx = S_IDLE;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         cnt        <= '0;
         idx        <= '0;
         sr         <= '0;
         code       <= ST_OK;
         status     <= ST_OK;
         hum_int    <= '0;
         hum_dec    <= '0;
         temp_int   <= '0;
         temp_dec   <= '0;
         holdoff_ok <= 1'b1;
      end else begin
         state <= state_nx;
         code  <= code_nx;

         // One counter serves every state; in IDLE it times the holdoff and then parks.
         if (state_nx != state) begin
            cnt <= '0;
         end else if (!(state == S_IDLE && holdoff_ok)) begin
            cnt <= cnt + CNT_ONE;
         end

         if (state == S_FIN) begin
            holdoff_ok <= 1'b0;
         end else if (state == S_IDLE && !holdoff_ok && cnt == HOLD_LAST) begin
            holdoff_ok <= 1'b1;
         end

         if (state == S_IDLE && state_nx == S_START_LOW) begin
            sr <= '0;
         end

         if (state == S_RESP_HIGH && fall) begin
            idx <= '0;
         end

         if (state == S_BIT_HIGH && fall) begin
            sr  <= {sr[FRAME_BITS-2:0], (cnt >= THRESH)};
            idx <= idx + 6'd1;
         end

         if (state == S_CHECK && cksum == sr[7:0]) begin
            hum_int  <= sr[39:32];
            hum_dec  <= sr[31:24];
            temp_int <= sr[23:16];
            temp_dec <= sr[15:8];
         end

         if (state == S_FIN) begin
            status <= code;
         end
      end
   end

   assign dq_oe = (state == S_START_LOW);
   assign busy  = (state != S_IDLE) && (state != S_FIN);
   assign done  = (state == S_FIN);

endmodule

// File: tb/tb_dht11_bus_controller.sv
// Directed bench: behavioural DHT11 on an open-drain line with pull-up, plus
// scripted transactions with hand-computed expected results.
module tb_dht11_bus_controller;
   import dht11_pkg::*;

   localparam int unsigned T_START = 1800;
   localparam int unsigned T_REL   = 30;
   localparam int unsigned T_TMO   = 200;
   localparam int unsigned T_THR   = 50;
   localparam int unsigned T_HOLD  = 3000;

   logic       clk     = 1'b0;
   logic       rst     = 1'b1;
   logic       start   = 1'b0;
   logic       sen_low = 1'b0;
   logic       dq;
   logic       dq_oe;
   logic       busy;
   logic       done;
   logic [1:0] status;
   logic [7:0] hum_int;
   logic [7:0] hum_dec;
   logic [7:0] temp_int;
   logic [7:0] temp_dec;

   // Either side pulling low wins; otherwise the pull-up holds the line high.
   assign dq = ~(dq_oe | sen_low);

   dht11_bus_controller #(
      .START_LOW_CYC  (T_START),
      .RELEASE_CYC    (T_REL),
      .TIMEOUT_CYC    (T_TMO),
      .BIT_THRESH_CYC (T_THR),
      .HOLDOFF_CYC    (T_HOLD)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .dq_in    (dq),
      .dq_oe    (dq_oe),
      .busy     (busy),
      .done     (done),
      .status   (status),
      .hum_int  (hum_int),
      .hum_dec  (hum_dec),
      .temp_int (temp_int),
      .temp_dec (temp_dec)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   int unsigned done_cnt    = 0;
   int unsigned done_cyc    = 0;
   int unsigned oe_rises    = 0;
   int unsigned oe_rise_cyc = 0;
   int unsigned oe_run      = 0;
   int unsigned oe_len      = 0;
   logic        oe_prev     = 1'b0;

   always @(negedge clk) begin
      if (dq_oe && !oe_prev) begin
         oe_rises++;
         oe_rise_cyc = cyc;
         oe_run = 0;
      end
      if (dq_oe) oe_run++;
      else if (oe_prev) oe_len = oe_run;
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      oe_prev = dq_oe;
   end

   // Sensor model: response 80 low / 80 high, bits 50 low + 27 (0) or 70 (1) high.
   logic [39:0] s_frame       = '0;
   int unsigned s_stop        = 40;
   bit          s_resp        = 1'b1;
   bit          s_active      = 1'b0;
   int unsigned s_bit         = 0;
   int unsigned last_edge_cyc = 0;

   task automatic hold(input logic lvl, input int unsigned n);
      sen_low = lvl;
      repeat (n) @(negedge clk);
   endtask

   initial begin : sensor_model
      forever begin
         @(posedge dq_oe);
         @(negedge dq_oe);
         if (s_resp) begin
            s_active = 1'b1;
            @(negedge clk);
            hold(1'b0, 30);
            hold(1'b1, 80);
            hold(1'b0, 80);
            for (int unsigned i = 0; i < 40; i++) begin
               s_bit = i;
               hold(1'b1, 50);
               sen_low = 1'b0;
               last_edge_cyc = cyc;
               if (i == s_stop) break;
               repeat (s_frame[39-i] ? 70 : 27) @(negedge clk);
            end
            if (s_stop >= 40) hold(1'b1, 50);
            sen_low  = 1'b0;
            s_active = 1'b0;
         end
      end
   end

   task automatic run_txn(input string tag, input logic [39:0] frame, input int unsigned stop,
                          input bit resp, input bit poke);
      int unsigned d0;
      int unsigned r0;
      int unsigned t;
      s_frame = frame;
      s_stop  = stop;
      s_resp  = resp;
      d0 = done_cnt;
      r0 = oe_rises;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({tag, ".busy_on_start"}, 32'(busy), 32'd1);
      check({tag, ".oe_on_start"}, 32'(dq_oe), 32'd1);
      if (poke) begin
         repeat (100) @(negedge clk);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      t = 0;
      while (done_cnt == d0 && t < 40000) begin
         @(negedge clk);
         t++;
      end
      check({tag, ".done_seen"}, 32'(done_cnt != d0), 32'd1);
      if (poke) begin
         repeat (9) @(negedge clk);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         @(negedge clk);
         check({tag, ".busy_after_late_start"}, 32'(busy), 32'd0);
         check({tag, ".oe_after_late_start"}, 32'(dq_oe), 32'd0);
      end
      t = 0;
      while (s_active && t < 2000) begin
         @(negedge clk);
         t++;
      end
      @(negedge clk);
      check({tag, ".done_pulses"}, done_cnt - d0, 32'd1);
      check({tag, ".oe_pulses"}, oe_rises - r0, 32'd1);
      check({tag, ".busy_after_done"}, 32'(busy), 32'd0);
   endtask

   task automatic check_bytes(input string tag, input logic [31:0] exp);
      check({tag, ".hum_int"},  32'(hum_int),  32'(exp[31:24]));
      check({tag, ".hum_dec"},  32'(hum_dec),  32'(exp[23:16]));
      check({tag, ".temp_int"}, 32'(temp_int), 32'(exp[15:8]));
      check({tag, ".temp_dec"}, 32'(temp_dec), 32'(exp[7:0]));
   endtask

   initial begin : watchdog
      repeat (200000) @(posedge clk);
      $display("FAIL watchdog: got no finish, expected finish within 200000 cycles");
      $fatal(1);
   end

   initial begin : main
      int unsigned diff;
      int unsigned d0;
      int unsigned t;

      repeat (3) @(negedge clk);
      check("reset.dq_oe",  32'(dq_oe),  32'd0);
      check("reset.busy",   32'(busy),   32'd0);
      check("reset.done",   32'(done),   32'd0);
      check("reset.status", 32'(status), 32'd0);
      check_bytes("reset", 32'h0000_0000);

      // Start in the very first cycle after reset, with starts poked while busy and after done.
      rst = 1'b0;
      run_txn("nominal", 40'h37_0019_0050, 40, 1'b1, 1'b1);
      check("nominal.oe_len", oe_len, T_START);
      check("nominal.status", 32'(status), 32'(ST_OK));
      check_bytes("nominal", 32'h3700_1900);

      repeat (T_HOLD + 10) @(negedge clk);
      run_txn("good2", 40'h41_0217_055F, 40, 1'b1, 1'b0);
      check("good2.status", 32'(status), 32'(ST_OK));
      check_bytes("good2", 32'h4102_1705);

      repeat (T_HOLD + 10) @(negedge clk);
      run_txn("cksum", 40'h37_0019_0051, 40, 1'b1, 1'b0);
      check("cksum.status", 32'(status), 32'(ST_CKSUM));
      check_bytes("cksum", 32'h4102_1705);

      repeat (T_HOLD + 10) @(negedge clk);
      run_txn("silent", 40'h00_0000_0000, 40, 1'b0, 1'b0);
      check("silent.status", 32'(status), 32'(ST_NORESP));
      diff = done_cyc - oe_rise_cyc;
      check("silent.latency_window",
            32'(diff >= T_START + T_REL + T_TMO - 2 && diff <= T_START + T_REL + T_TMO + 2), 32'd1);
      check_bytes("silent", 32'h4102_1705);

      repeat (T_HOLD + 10) @(negedge clk);
      run_txn("midframe", 40'h37_0019_0050, 20, 1'b1, 1'b0);
      check("midframe.status", 32'(status), 32'(ST_TIMEOUT));
      diff = done_cyc - last_edge_cyc;
      check("midframe.latency_window", 32'(diff >= T_TMO && diff <= T_TMO + 6), 32'd1);
      check_bytes("midframe", 32'h4102_1705);

      repeat (T_HOLD + 10) @(negedge clk);
      s_frame = 40'h41_0217_055F;
      s_stop  = 40;
      s_resp  = 1'b1;
      d0 = done_cnt;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("holdoff.start_accepted", 32'(busy), 32'd1);
      t = 0;
      while (!(s_active && s_bit == 10) && t < 20000) begin
         @(negedge clk);
         t++;
      end
      check("rst.reached_bit10", 32'(s_active && s_bit == 10), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check("rst.dq_oe", 32'(dq_oe), 32'd0);
      check("rst.busy",  32'(busy),  32'd0);
      rst = 1'b0;
      t = 0;
      while (s_active && t < 10000) begin
         @(negedge clk);
         t++;
      end
      @(negedge clk);
      check("rst.no_done", done_cnt - d0, 32'd0);
      check("rst.status", 32'(status), 32'(ST_OK));
      check_bytes("rst", 32'h0000_0000);

      run_txn("after_rst", 40'h37_0019_0050, 40, 1'b1, 1'b0);
      check("after_rst.status", 32'(status), 32'(ST_OK));
      check_bytes("after_rst", 32'h3700_1900);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
